core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 160 ++++++++++++++++
 tb/tb_core_seq.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// core_seq: single-issue instruction sequencer.
//
// Walks one instruction at a time through fetch, decode, execute and
// writeback. It hands the fetched word to an external decoder and execute
// unit and strobes the register file once per retired instruction.
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous reset, active low
//   imem_req      fetch request, held with imem_addr until imem_gnt
//   imem_addr     fetch address (always equal to pc)
//   imem_gnt      fetch request accepted this cycle
//   imem_rvalid   fetch data valid (only honoured while waiting for data)
//   imem_rdata    fetched instruction word
//   inst          instruction register driven to decode
//   inst_valid    inst holds an instruction in flight
//   dec_illegal   decoder rejected inst
//   dec_rd_w_ena  decoder requests a register write for inst
//   exe_busy      execute unit needs more cycles
//   wb_ena        register-file write strobe, one cycle per instruction
//   halt_req      stop at the next instruction boundary
//   halted        sequencer is parked in HALT
//   trap          sticky illegal-instruction flag (cleared only by reset)
//   pc            address of the current instruction
//   retired       retired-instruction counter
module core_seq #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        dec_illegal,
  input  logic        dec_rd_w_ena,
  input  logic        exe_busy,
  output logic        wb_ena,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic [63:0] pc,
  output logic [63:0] retired
);

  localparam logic [63:0] PC_INC = 64'(PC_STEP);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALT
  } state_t;

  state_t state;

  // The fetch address is the architectural pc; no separate fetch pointer.
  assign imem_addr = pc;

  // All outputs are registered and updated together with the state they
  // belong to, so each output changes exactly on the state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= '0;
      retired    <= '0;
      trap       <= 1'b0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      wb_ena     <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state    <= FETCH_REQ;
            imem_req <= 1'b1;
          end
        end

        // Data can only arrive after the grant, so rvalid is ignored here.
        FETCH_REQ: begin
          if (imem_gnt) begin
            state    <= FETCH_WAIT;
            imem_req <= 1'b0;
          end
        end

        // No timeout: the memory is trusted to answer eventually.
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= DECODE;
          end
        end

        // An illegal instruction parks the core without retiring it.
        DECODE: begin
          if (dec_illegal) begin
            state      <= HALT;
            trap       <= 1'b1;
            halted     <= 1'b1;
            inst_valid <= 1'b0;
          end else begin
            state <= EXECUTE;
          end
        end

        // The write strobe is registered here from the stable decode of inst
        // so that it is high for exactly the single WRITEBACK cycle.
        EXECUTE: begin
          if (!exe_busy) begin
            state  <= WRITEBACK;
            wb_ena <= dec_rd_w_ena;
          end
        end

        WRITEBACK: begin
          wb_ena     <= 1'b0;
          inst_valid <= 1'b0;
          pc         <= pc + PC_INC;
          retired    <= retired + 64'd1;
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state    <= FETCH_REQ;
            imem_req <= 1'b1;
          end
        end

        // A trapped core stays here until reset.
        HALT: begin
          if (!halt_req && !trap) begin
            state    <= FETCH_REQ;
            halted   <= 1'b0;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq. A memory responder serves words from a
// program queue and, on delivering each word, pushes the expected outcome of
// that instruction into a scoreboard. A monitor pops and compares whenever an
// instruction leaves the in-flight window (inst_valid falling).
module tb_core_seq;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        rst;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_illegal;
  logic        dec_rd_w_ena;
  logic        exe_busy;
  logic        halt_req;

  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        wb_ena;
  logic        halted;
  logic        trap;
  logic [63:0] pc;
  logic [63:0] retired;

  logic        w_imem_req;
  logic [63:0] w_imem_addr;
  logic [31:0] w_inst;
  logic        w_inst_valid;
  logic        w_wb_ena;
  logic        w_halted;
  logic        w_trap;
  logic [63:0] w_pc;
  logic [63:0] w_retired;

  core_seq #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_valid(inst_valid),
    .dec_illegal(dec_illegal), .dec_rd_w_ena(dec_rd_w_ena), .exe_busy(exe_busy),
    .wb_ena(wb_ena), .halt_req(halt_req), .halted(halted), .trap(trap),
    .pc(pc), .retired(retired)
  );

  // Second instance near the top of the address space, driven by the same
  // stimulus, to observe pc wrap-around.
  core_seq #(.RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(w_inst), .inst_valid(w_inst_valid),
    .dec_illegal(dec_illegal), .dec_rd_w_ena(dec_rd_w_ena), .exe_busy(exe_busy),
    .wb_ena(w_wb_ena), .halt_req(halt_req), .halted(w_halted), .trap(w_trap),
    .pc(w_pc), .retired(w_retired)
  );

  typedef struct {
    logic [31:0] word;
    logic [63:0] pc;
    logic [63:0] ret;
    logic        wb;
    logic        illegal;
    logic        halt;
    int          win;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  longint      wb_times[$];

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  logic [63:0] model_pc;
  logic [63:0] model_ret;
  int          gdly_cfg;
  int          rdly_cfg;
  bit          junk_en;
  bit          mem_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 500000", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what one delivered word must do, from the rules of the
  // sequencer. Opcode 0 is illegal; bit 7 asks for a register write; bits
  // [11:9] give the extra execute cycles. A legal instruction is in flight for
  // decode (1) + execute (busy+1) + writeback (1) cycles.
  function automatic void issue(input logic [31:0] w);
    exp_t e;
    e.word    = w;
    e.illegal = (w[6:0] == 7'h00);
    e.wb      = !e.illegal && w[7];
    e.win     = e.illegal ? 1 : int'(w[11:9]) + 3;
    if (!e.illegal) begin
      model_pc  = model_pc + 64'd4;
      model_ret = model_ret + 64'd1;
    end
    e.pc   = model_pc;
    e.ret  = model_ret;
    e.halt = e.illegal || halt_req;
    sb.push_back(e);
  endfunction

  function automatic logic probe(input int which);
    case (which)
      0:       return imem_req;
      1:       return inst_valid;
      default: return trap;
    endcase
  endfunction

  task automatic wait_ret(input logic [63:0] target, input int budget);
    int n;
    n = 0;
    while (retired !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("retire_wait", retired, target);
  endtask

  task automatic wait_probe(input string name, input int which, input logic val, input int budget);
    int n;
    n = 0;
    while (probe(which) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(probe(which)), 64'(val));
  endtask

  // Decoder / execute unit model, driven from the visible instruction.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      dec_rd_w_ena = inst[7];
      dec_illegal  = (inst[6:0] == 7'h00);
      if (inst_valid) begin
        // Busy during decode is deliberate: it must not delay anything.
        exe_busy = (k == 0) ? 1'b1 : ((k - 1) < int'(inst[11:9]));
        k++;
      end else begin
        k = 0;
        exe_busy = 1'($urandom_range(0, 1));
      end
    end
  end

  // Instruction memory responder.
  initial begin
    int phase;
    int gwait;
    int rwait;
    logic [31:0] cur;
    phase = 0;
    gwait = -1;
    rwait = 0;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (!mem_en) continue;
      if (!rst) begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        phase       = 0;
        gwait       = -1;
      end else if (phase == 1) begin
        imem_gnt = 1'b0;
        chk("req_low_in_wait", 64'(imem_req), 64'd0);
        if (rwait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = cur;
          issue(cur);
          phase = 0;
        end else begin
          rwait--;
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
        end
      end else begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        if (imem_req) begin
          chk("imem_addr", imem_addr, model_pc);
          if (junk_en) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
          end
          if (prog.size() > 0) begin
            if (gwait < 0) gwait = (gdly_cfg >= 0) ? gdly_cfg : int'($urandom_range(0, 3));
            if (gwait == 0) begin
              imem_gnt = 1'b1;
              cur      = prog.pop_front();
              gwait    = -1;
              rwait    = (rdly_cfg >= 0) ? rdly_cfg : int'($urandom_range(0, 3));
              phase    = 1;
            end else begin
              gwait--;
            end
          end
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    bit prev;
    int win;
    int wbc;
    logic [31:0] cap;
    exp_t e;
    prev = 1'b0;
    win  = 0;
    wbc  = 0;
    cap  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b0;
        continue;
      end
      if (inst_valid && !prev) begin
        win = 0;
        wbc = 0;
        cap = inst;
      end
      if (inst_valid) win++;
      if (wb_ena) begin
        wbc++;
        wb_times.push_back(cyc);
        chk("wb_in_window", 64'(inst_valid), 64'd1);
      end
      if (!inst_valid && prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: instruction 0x%0h completed, expected none", cap);
        end else begin
          e = sb.pop_front();
          chk("inst", 64'(cap), 64'(e.word));
          chk("inst_hold", 64'(inst), 64'(e.word));
          chk("pc", pc, e.pc);
          chk("retired", retired, e.ret);
          chk("wb_count", 64'(wbc), 64'(e.wb));
          chk("window", 64'(win), 64'(e.win));
          chk("trap", 64'(trap), 64'(e.illegal));
          chk("halted", 64'(halted), 64'(e.halt));
        end
      end
      prev = inst_valid;
    end
  end

  initial begin
    logic [31:0] w;
    logic [63:0] pc_s;
    rst          = 1'b1;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    dec_illegal  = 1'b0;
    dec_rd_w_ena = 1'b0;
    exe_busy     = 1'b0;
    halt_req     = 1'b0;
    mem_en       = 1'b1;
    junk_en      = 1'b0;
    gdly_cfg     = 0;
    rdly_cfg     = 0;
    model_pc     = RST_PC;
    model_ret    = '0;

    // Reset state, observed without any clock edge after assertion.
    #3 rst = 1'b0;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_wb_ena", 64'(wb_ena), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_retired", retired, 64'd0);
    chk("rst_wrap_pc", w_pc, WRAP_PC);

    // Zero-wait fetch, three writing instructions.
    prog.push_back(32'h0010_0093);
    prog.push_back(32'h0020_0093);
    prog.push_back(32'h0030_0093);
    @(negedge clk);
    #1 rst = 1'b1;
    chk("req_in_idle", 64'(imem_req), 64'd0);
    @(negedge clk);
    chk("req_after_idle", 64'(imem_req), 64'd1);
    wait_ret(64'd1, 20);
    chk("wrap_pc_zero", w_pc, 64'd0);
    chk("wrap_retired", w_retired, 64'd1);
    wait_ret(64'd3, 30);
    chk("pc_after_3", pc, 64'h0000_0000_8000_000C);
    chk("wrap_pc_after_3", w_pc, 64'd8);
    chk("wb_pulses", 64'(wb_times.size()), 64'd3);
    if (wb_times.size() >= 3) begin
      chk("wb_spacing_1", 64'(wb_times[1] - wb_times[0]), 64'd5);
      chk("wb_spacing_2", 64'(wb_times[2] - wb_times[1]), 64'd5);
    end

    // Fetch backpressure with spurious rvalid while the request is pending.
    gdly_cfg = 3;
    rdly_cfg = 2;
    junk_en  = 1'b1;
    @(negedge clk);
    #1 prog.push_back(32'h0010_0093);
    wait_ret(64'd4, 40);
    chk("ir_capture", 64'(inst), 64'h0010_0093);

    // Multicycle execute: four busy cycles.
    gdly_cfg = 0;
    rdly_cfg = 0;
    junk_en  = 1'b0;
    @(negedge clk);
    #1 prog.push_back(32'h0000_0893);
    wait_ret(64'd5, 40);
    chk("wb_total", 64'(wb_times.size()), 64'd5);

    // Halt requested while the fetch is outstanding.
    gdly_cfg = 1;
    rdly_cfg = 2;
    @(negedge clk);
    #1 prog.push_back(32'h0050_0093);
    wait_probe("enter_fetch_wait", 0, 1'b0, 20);
    #1 halt_req = 1'b1;
    wait_ret(64'd6, 40);
    repeat (3) begin
      @(negedge clk);
      chk("halt_held", 64'(halted), 64'd1);
      chk("halt_no_req", 64'(imem_req), 64'd0);
    end
    #1 halt_req = 1'b0;
    @(negedge clk);
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", imem_addr, model_pc);
    chk("resume_pc", pc, 64'h0000_0000_8000_0018);
    chk("resume_halted", 64'(halted), 64'd0);

    // Randomised run.
    gdly_cfg = -1;
    rdly_cfg = -1;
    junk_en  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w = $urandom;
      w[6:0] = 7'h13;
      prog.push_back(w);
    end
    wait_ret(64'd36, 1500);

    // Illegal instruction: trap is sticky, nothing retires, halt_req ignored.
    gdly_cfg = 0;
    rdly_cfg = 0;
    junk_en  = 1'b0;
    @(negedge clk);
    #1 prog.push_back(32'h0000_1000);
    wait_probe("trap_set", 2, 1'b1, 40);
    pc_s = model_pc;
    prog.push_back(32'h0010_0093);
    for (int i = 0; i < 6; i++) begin
      #1 halt_req = (i % 2 == 0);
      @(negedge clk);
      chk("trap_halted", 64'(halted), 64'd1);
      chk("trap_sticky", 64'(trap), 64'd1);
      chk("trap_no_req", 64'(imem_req), 64'd0);
      chk("trap_pc", pc, pc_s);
      chk("trap_retired", retired, 64'd36);
      chk("trap_no_wb", 64'(wb_ena), 64'd0);
    end
    halt_req = 1'b0;
    chk("trap_no_fetch", 64'(prog.size()), 64'd1);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    // Reset clears trap; then reset in the middle of execute.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst2_trap", 64'(trap), 64'd0);
    chk("rst2_halted", 64'(halted), 64'd0);
    chk("rst2_pc", pc, RST_PC);
    prog.delete();
    sb.delete();
    model_pc  = RST_PC;
    model_ret = '0;
    prog.push_back(32'h0010_0093);
    prog.push_back(32'h0000_0893);
    @(negedge clk);
    #1 rst = 1'b1;
    wait_ret(64'd1, 20);
    wait_probe("second_in_flight", 1, 1'b1, 20);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midexe_inst_valid", 64'(inst_valid), 64'd0);
    chk("midexe_inst", 64'(inst), 64'd0);
    chk("midexe_pc", pc, RST_PC);
    chk("midexe_addr", imem_addr, RST_PC);
    chk("midexe_retired", retired, 64'd0);
    chk("midexe_wb", 64'(wb_ena), 64'd0);
    chk("midexe_req", 64'(imem_req), 64'd0);
    chk("midexe_halted", 64'(halted), 64'd0);
    chk("midexe_wrap_pc", w_pc, WRAP_PC);
    chk("midexe_wrap_ret", w_retired, 64'd0);
    sb.delete();
    prog.delete();
    model_pc  = RST_PC;
    model_ret = '0;

    // Reset during an outstanding fetch; a late rvalid must be ignored.
    mem_en      = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    wait_probe("late_req", 0, 1'b1, 10);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("late_in_wait", 64'(imem_req), 64'd0);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0BAD;
    @(negedge clk);
    chk("late_inst_idle", 64'(inst), 64'd0);
    chk("late_valid_idle", 64'(inst_valid), 64'd0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("late_inst_req", 64'(inst), 64'd0);
    chk("late_req_again", 64'(imem_req), 64'd1);
    chk("late_addr", imem_addr, RST_PC);
    repeat (2) begin
      @(negedge clk);
      chk("late_no_valid", 64'(inst_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
